// File: rtl/spi_shift_engine.sv
// spi_shift_engine: SPI serialiser/deserialiser with one-entry TX holding buffer and RX holding register
module spi_shift_engine #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  ss,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  lsbfe,
  input  logic                  mosi_send_sclk,
  input  logic                  mosi_send_sclk0,
  input  logic                  miso_receive_sclk,
  input  logic                  miso_receive_sclk0,
  input  logic                  miso,
  input  logic                  tx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_ready,
  input  logic                  rx_read,
  input  logic                  ovr_clr,
  output logic                  mosi,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  rx_overrun,
  output logic                  busy,
  output logic                  frame_done
);
  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DATA_WIDTH);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] XFER = 2'd2;
  logic [1:0] state;
  logic [DATA_WIDTH-1:0] hold, shift_tx, shift_rx, rx_next, tx_shifted;
  logic hold_full, sel, lsb_r, send_stb, rx_stb, out_bit, last_rx;
  logic [CW-1:0] tx_cnt, rx_cnt;
  assign tx_ready = ~hold_full;
  assign busy = state != IDLE;
  always_comb begin
    send_stb = sel ? mosi_send_sclk0 : mosi_send_sclk;
    rx_stb = sel ? miso_receive_sclk0 : miso_receive_sclk;
    out_bit = lsb_r ? shift_tx[0] : shift_tx[DATA_WIDTH-1];
    tx_shifted = lsb_r ? shift_tx >> 1 : shift_tx << 1;
    rx_next = lsb_r ? {miso, shift_rx[DATA_WIDTH-1:1]} : {shift_rx[DATA_WIDTH-2:0], miso};
    last_rx = rx_stb && rx_cnt == LAST;
  end
  always_ff @(posedge pclk) begin
    if (preset) begin
      state <= IDLE;
      hold <= '0;
      hold_full <= 1'b0;
      shift_tx <= '0;
      shift_rx <= '0;
      tx_cnt <= '0;
      rx_cnt <= '0;
      sel <= 1'b0;
      lsb_r <= 1'b0;
      mosi <= 1'b0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      rx_overrun <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (tx_valid && tx_ready) begin
        hold <= tx_data;
        hold_full <= 1'b1;
      end
      if (rx_read) rx_valid <= 1'b0;
      if (ovr_clr) rx_overrun <= 1'b0;
      if (state == IDLE) begin
        if (!ss && hold_full) state <= LOAD;
      end else if (ss) begin
        state <= IDLE;
      end else if (state == LOAD) begin
        shift_tx <= cpha ? hold : (lsbfe ? hold >> 1 : hold << 1);
        mosi <= cpha ? mosi : (lsbfe ? hold[0] : hold[DATA_WIDTH-1]);
        tx_cnt <= cpha ? '0 : CW'(1);
        rx_cnt <= '0;
        sel <= cpol ^ cpha;
        lsb_r <= lsbfe;
        hold_full <= 1'b0;
        state <= XFER;
      end else begin
        if (send_stb && tx_cnt < FULL) begin
          mosi <= out_bit;
          shift_tx <= tx_shifted;
          tx_cnt <= tx_cnt + 1'b1;
        end
        if (rx_stb) begin
          shift_rx <= rx_next;
          rx_cnt <= rx_cnt + 1'b1;
        end
        if (last_rx) begin
          rx_data <= rx_next;
          rx_valid <= 1'b1;
          frame_done <= 1'b1;
          if (rx_valid && !rx_read) rx_overrun <= 1'b1;
          state <= hold_full ? LOAD : IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_shift_engine.sv
// tb_spi_shift_engine: table-driven and randomized frame-level checks of spi_shift_engine (W=8 and W=16)
module tb_spi_shift_engine;
  logic pclk = 1'b0, preset = 1'b1, ss = 1'b1, cpol = 1'b0, cpha = 1'b0, lsbfe = 1'b0;
  logic mosi_send_sclk = 1'b0, mosi_send_sclk0 = 1'b0, miso_receive_sclk = 1'b0, miso_receive_sclk0 = 1'b0;
  logic miso = 1'b0, rx_read = 1'b0, ovr_clr = 1'b0, tx_valid8 = 1'b0, tx_valid16 = 1'b0;
  logic [7:0] tx_data8 = '0, rx_data8;
  logic [15:0] tx_data16 = '0, rx_data16;
  logic tx_ready8, mosi8, rx_valid8, rx_overrun8, busy8, frame_done8;
  logic tx_ready16, mosi16, rx_valid16, rx_overrun16, busy16, frame_done16;
  typedef struct {
    logic [15:0] word;
    bit pol, pha, lsb;
    int mm;
    bit noise, rd;
    logic [15:0] exp_rx;
  } vec_t;
  vec_t tbl[6];
  int vectors = 0, miscompares = 0, fd_cnt = 0;
  bit w16 = 1'b0, busy_gap = 1'b0;
  bit m_valid[2], m_ovr[2];
  logic [15:0] got;
  always #5 pclk = ~pclk;
  spi_shift_engine #(.DATA_WIDTH(8)) u8 (
    .pclk(pclk), .preset(preset), .ss(ss), .cpol(cpol), .cpha(cpha), .lsbfe(lsbfe),
    .mosi_send_sclk(mosi_send_sclk), .mosi_send_sclk0(mosi_send_sclk0),
    .miso_receive_sclk(miso_receive_sclk), .miso_receive_sclk0(miso_receive_sclk0), .miso(miso),
    .tx_valid(tx_valid8), .tx_data(tx_data8), .tx_ready(tx_ready8), .rx_read(rx_read), .ovr_clr(ovr_clr),
    .mosi(mosi8), .rx_data(rx_data8), .rx_valid(rx_valid8), .rx_overrun(rx_overrun8),
    .busy(busy8), .frame_done(frame_done8)
  );
  spi_shift_engine #(.DATA_WIDTH(16)) u16 (
    .pclk(pclk), .preset(preset), .ss(ss), .cpol(cpol), .cpha(cpha), .lsbfe(lsbfe),
    .mosi_send_sclk(mosi_send_sclk), .mosi_send_sclk0(mosi_send_sclk0),
    .miso_receive_sclk(miso_receive_sclk), .miso_receive_sclk0(miso_receive_sclk0), .miso(miso),
    .tx_valid(tx_valid16), .tx_data(tx_data16), .tx_ready(tx_ready16), .rx_read(rx_read), .ovr_clr(ovr_clr),
    .mosi(mosi16), .rx_data(rx_data16), .rx_valid(rx_valid16), .rx_overrun(rx_overrun16),
    .busy(busy16), .frame_done(frame_done16)
  );
  function automatic logic cur_mosi(); return w16 ? mosi16 : mosi8; endfunction
  function automatic logic cur_busy(); return w16 ? busy16 : busy8; endfunction
  function automatic logic cur_ready(); return w16 ? tx_ready16 : tx_ready8; endfunction
  function automatic logic cur_fd(); return w16 ? frame_done16 : frame_done8; endfunction
  function automatic logic cur_valid(); return w16 ? rx_valid16 : rx_valid8; endfunction
  function automatic logic cur_ovr(); return w16 ? rx_overrun16 : rx_overrun8; endfunction
  function automatic logic [15:0] cur_rx(); return w16 ? rx_data16 : {8'h00, rx_data8}; endfunction
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge pclk);
    #1;
    fd_cnt += int'(cur_fd());
    if (!cur_busy()) busy_gap = 1'b1;
  endtask
  task automatic strobe(input bit rx, input bit alt, input bit rd);
    mosi_send_sclk = !rx && !alt;
    mosi_send_sclk0 = !rx && alt;
    miso_receive_sclk = rx && !alt;
    miso_receive_sclk0 = rx && alt;
    rx_read = rd;
    tick();
    {mosi_send_sclk, mosi_send_sclk0, miso_receive_sclk, miso_receive_sclk0, rx_read} = '0;
    tick();
  endtask
  task automatic write_hold(input logic [15:0] word);
    int n = 0;
    while (!cur_ready() && n < 50) begin tick(); n++; end
    check("tx_ready_before_write", 16'(cur_ready()), 16'd1);
    if (w16) begin tx_valid16 = 1'b1; tx_data16 = word; end
    else begin tx_valid8 = 1'b1; tx_data8 = word[7:0]; end
    tick();
    tx_valid8 = 1'b0;
    tx_valid16 = 1'b0;
  endtask
  task automatic start();
    int n = 0;
    ss = 1'b0;
    while (!cur_busy() && n < 20) begin tick(); n++; end
    check("busy_at_start", 16'(cur_busy()), 16'd1);
    tick();
  endtask
  task automatic shift_bits(input logic [15:0] word, input int n, input bit cp, input bit lsb, input bit alt,
                            input int mm, input bit noise, input bit rd, output logic [15:0] rx_exp);
    int wd = w16 ? 16 : 8;
    rx_exp = '0;
    for (int i = 0; i < n; i++) begin
      int pos;
      pos = lsb ? i : wd - 1 - i;
      if (noise) begin strobe(0, !alt, 0); strobe(1, !alt, 0); end
      if (cp) strobe(0, alt, 0);
      check("mosi_bit", 16'(cur_mosi()), 16'(word[pos]));
      if (!cp && i == wd - 1) begin
        strobe(0, alt, 0);
        check("mosi_hold_extra_send", 16'(cur_mosi()), 16'(word[pos]));
      end
      miso = (mm == 0) ? cur_mosi() : (mm == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      rx_exp[pos] = miso;
      strobe(1, alt, rd && i == wd - 1);
      if (!cp && i < wd - 1) strobe(0, alt, 0);
    end
  endtask
  task automatic run_frame(input logic [15:0] word, input bit pol, input bit pha, input bit lsb, input int mm,
                           input bit noise, input bit rd, output logic [15:0] rx_exp);
    int k = w16 ? 1 : 0;
    cpol = pol;
    cpha = pha;
    lsbfe = lsb;
    write_hold(word);
    start();
    fd_cnt = 0;
    shift_bits(word, w16 ? 16 : 8, pha, lsb, pol ^ pha, mm, noise, rd, rx_exp);
    m_ovr[k] = m_ovr[k] | (m_valid[k] & !rd);
    m_valid[k] = 1'b1;
    check("rx_data", cur_rx(), rx_exp);
    check("rx_valid", 16'(cur_valid()), 16'(m_valid[k]));
    check("rx_overrun", 16'(cur_ovr()), 16'(m_ovr[k]));
    check("frame_done_count", 16'(fd_cnt), 16'd1);
    check("busy_after_frame", 16'(cur_busy()), 16'd0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    tbl[0] = '{16'h00A5, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 16'h00A5};
    tbl[1] = '{16'h003C, 1'b1, 1'b1, 1'b1, 1, 1'b0, 1'b0, 16'h00FF};
    tbl[2] = '{16'h0081, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 16'h0081};
    tbl[3] = '{16'h0081, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 16'h0081};
    tbl[4] = '{16'h005A, 1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0, 16'h005A};
    tbl[5] = '{16'h00C3, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b1, 16'h00C3};
    m_valid = '{1'b0, 1'b0};
    m_ovr = '{1'b0, 1'b0};
    repeat (3) tick();
    preset = 1'b0;
    tick();
    check("reset_tx_ready", 16'(tx_ready8), 16'd1);
    check("reset_mosi", 16'(mosi8), 16'd0);
    check("reset_rx_data", 16'(rx_data8), 16'd0);
    check("reset_flags", 16'({rx_valid8, rx_overrun8, busy8, frame_done8}), 16'd0);
    for (int i = 0; i < 6; i++) begin
      ovr_clr = 1'b1;
      tick();
      ovr_clr = 1'b0;
      m_ovr[0] = 1'b0;
      run_frame(tbl[i].word, tbl[i].pol, tbl[i].pha, tbl[i].lsb, tbl[i].mm, tbl[i].noise, tbl[i].rd, got);
      check("table_rx_expected", cur_rx(), tbl[i].exp_rx);
    end
    rx_read = 1'b1;
    ovr_clr = 1'b1;
    tick();
    rx_read = 1'b0;
    ovr_clr = 1'b0;
    m_valid[0] = 1'b0;
    m_ovr[0] = 1'b0;
    check("rx_read_clears_valid", 16'(rx_valid8), 16'd0);
    cpol = 1'b0;
    cpha = 1'b0;
    lsbfe = 1'b0;
    write_hold(16'h0011);
    start();
    write_hold(16'h0022);
    busy_gap = 1'b0;
    fd_cnt = 0;
    shift_bits(16'h0011, 8, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, got);
    check("b2b_no_idle", 16'(busy_gap), 16'd0);
    check("b2b_first_rx", cur_rx(), 16'h0011);
    shift_bits(16'h0022, 8, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, got);
    check("b2b_second_rx", cur_rx(), 16'h0022);
    check("b2b_overrun", 16'(rx_overrun8), 16'd1);
    check("b2b_frame_done_count", 16'(fd_cnt), 16'd2);
    m_valid[0] = 1'b1;
    m_ovr[0] = 1'b1;
    repeat (2) tick();
    check("b2b_overrun_sticky", 16'(rx_overrun8), 16'd1);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    m_ovr[0] = 1'b0;
    check("ovr_clr", 16'(rx_overrun8), 16'd0);
    write_hold(16'h00F0);
    start();
    fd_cnt = 0;
    shift_bits(16'h00F0, 3, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, got);
    ss = 1'b1;
    repeat (2) tick();
    check("abort_idle", 16'(busy8), 16'd0);
    check("abort_no_frame_done", 16'(fd_cnt), 16'd0);
    check("abort_rx_valid", 16'(rx_valid8), 16'(m_valid[0]));
    check("abort_rx_data", cur_rx(), 16'h0022);
    check("abort_mosi_hold", 16'(mosi8), 16'd1);
    run_frame(16'h00F0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, got);
    check("after_abort_full_frame", cur_rx(), 16'h00F0);
    for (int k = 0; k < 30; k++) begin
      logic [15:0] wd;
      wd = 16'($urandom_range(0, 255));
      if ($urandom_range(0, 2) == 0) begin
        rx_read = 1'b1;
        tick();
        rx_read = 1'b0;
        m_valid[0] = 1'b0;
        check("rand_read_clear", 16'(rx_valid8), 16'd0);
      end
      if ($urandom_range(0, 3) == 0) begin
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        m_ovr[0] = 1'b0;
      end
      run_frame(wd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), got);
    end
    w16 = 1'b1;
    run_frame(16'hBEEF, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, got);
    check("w16_beef", rx_data16, 16'hBEEF);
    write_hold(16'h1234);
    start();
    shift_bits(16'h1234, 5, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, got);
    preset = 1'b1;
    tick();
    preset = 1'b0;
    check("preset_busy", 16'(busy16), 16'd0);
    check("preset_tx_ready", 16'(tx_ready16), 16'd1);
    check("preset_rx_data", rx_data16, 16'h0000);
    check("preset_flags", 16'({mosi16, rx_valid16, rx_overrun16, frame_done16}), 16'd0);
    repeat (3) tick();
    check("preset_hold_flushed", 16'(busy16), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
